// File: rtl/decode_pkg.sv
// Shared types for the RV32 decode stage: instruction classes, opcodes and the decoded field bundle.
package decode_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OPC_W   = 7;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned F3_W    = 3;
  localparam int unsigned F7_W    = 7;

  typedef enum logic [2:0] {
    T_R    = 3'b000,
    T_I    = 3'b001,
    T_U    = 3'b010,
    T_S    = 3'b011,
    T_B    = 3'b100,
    T_J    = 3'b101,
    T_LOAD = 3'b110,
    T_BAD  = 3'b111
  } instr_type_t;

  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;

  // Decoded bundle minus the immediate, whose width follows XLEN.
  typedef struct packed {
    instr_type_t       itype;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [F3_W-1:0]   funct3;
    logic [F7_W-1:0]   funct7;
  } decode_t;

  localparam decode_t DEC_RESET = '{itype: T_BAD, rd: '0, rs1: '0, rs2: '0, funct3: '0, funct7: '0};

endpackage

// File: rtl/decode_imm_gen.sv
// Combinational opcode classifier and sign-extended immediate generator.
module decode_imm_gen
  import decode_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter bit          ENABLE_EXT = 1'b1
) (
  input  logic [INSTR_W-1:0] instr,
  output instr_type_t        itype_c,
  output logic [XLEN-1:0]    imm_c
);

  logic [31:0] imm32;

  always_comb begin
    itype_c = T_BAD;
    imm32   = '0;
    case (instr[OPC_W-1:0])
      OPC_OP:     itype_c = T_R;
      OPC_OP_IMM: begin
        itype_c = T_I;
        imm32   = 32'($signed(instr[31:20]));
      end
      OPC_LUI, OPC_AUIPC: begin
        itype_c = T_U;
        imm32   = {instr[31:12], 12'b0};
      end
      OPC_LOAD: if (ENABLE_EXT) begin
        itype_c = T_LOAD;
        imm32   = 32'($signed(instr[31:20]));
      end
      OPC_STORE: if (ENABLE_EXT) begin
        itype_c = T_S;
        imm32   = 32'($signed({instr[31:25], instr[11:7]}));
      end
      OPC_BRANCH: if (ENABLE_EXT) begin
        itype_c = T_B;
        imm32   = 32'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      end
      OPC_JAL: if (ENABLE_EXT) begin
        itype_c = T_J;
        imm32   = 32'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      end
      default: ;
    endcase
    imm_c = XLEN'($signed(imm32));
  end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32 decode stage: decoder feeding a 2-entry skid buffer, plus a saturating illegal counter.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter bit          ENABLE_EXT = 1'b1,
  parameter int unsigned CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output instr_type_t        out_type,
  output logic [REG_W-1:0]   out_rd,
  output logic [REG_W-1:0]   out_rs1,
  output logic [REG_W-1:0]   out_rs2,
  output logic [F3_W-1:0]    out_funct3,
  output logic [F7_W-1:0]    out_funct7,
  output logic [XLEN-1:0]    out_imm,
  output logic               out_illegal,
  output logic [CNT_W-1:0]   illegal_count
);

  instr_type_t     dec_type_c;
  logic [XLEN-1:0] dec_imm_c;
  decode_t         in_dec_c;
  decode_t         m_dec, k_dec;
  logic [XLEN-1:0] m_imm, k_imm;
  logic            accept_c, m_free_c;

  decode_imm_gen #(.XLEN(XLEN), .ENABLE_EXT(ENABLE_EXT)) u_imm_gen (
    .instr   (in_instr),
    .itype_c (dec_type_c),
    .imm_c   (dec_imm_c)
  );

  assign in_dec_c = '{itype: dec_type_c, rd: in_instr[11:7], rs1: in_instr[19:15],
                      rs2: in_instr[24:20], funct3: in_instr[14:12], funct7: in_instr[31:25]};
  assign accept_c = in_valid && in_ready;
  assign m_free_c = !out_valid || out_ready;

  // Counts at the handshake, so flushed-away illegal words are still counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_count <= '0;
    end else if (accept_c && dec_type_c == T_BAD && illegal_count != {CNT_W{1'b1}}) begin
      illegal_count <= illegal_count + CNT_W'(1);
    end
  end

  // in_ready doubles as the "skid entry empty" flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      m_dec     <= DEC_RESET;
      k_dec     <= DEC_RESET;
      m_imm     <= '0;
      k_imm     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else if (m_free_c) begin
      if (!in_ready) begin
        m_dec     <= k_dec;
        m_imm     <= k_imm;
        out_valid <= 1'b1;
        in_ready  <= 1'b1;
      end else if (accept_c) begin
        m_dec     <= in_dec_c;
        m_imm     <= dec_imm_c;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept_c) begin
      k_dec    <= in_dec_c;
      k_imm    <= dec_imm_c;
      in_ready <= 1'b0;
    end
  end

  assign out_type    = m_dec.itype;
  assign out_rd      = m_dec.rd;
  assign out_rs1     = m_dec.rs1;
  assign out_rs2     = m_dec.rs2;
  assign out_funct3  = m_dec.funct3;
  assign out_funct7  = m_dec.funct7;
  assign out_imm     = m_imm;
  assign out_illegal = (m_dec.itype == T_BAD);

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: main config, a no-extension variant and a 2-bit counter variant share stimulus.
module tb_decode_stage;

  logic clk = 1'b0;
  logic rst, flush, in_valid, out_ready;
  logic [31:0] in_instr;

  logic        in_ready, out_valid, out_illegal;
  logic [2:0]  out_type;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [31:0] out_imm;
  logic [7:0]  illegal_count;

  logic        ne_in_ready, ne_out_valid, ne_out_illegal;
  logic [2:0]  ne_out_type;
  logic [4:0]  ne_out_rd, ne_out_rs1, ne_out_rs2;
  logic [2:0]  ne_out_funct3;
  logic [6:0]  ne_out_funct7;
  logic [31:0] ne_out_imm;
  logic [7:0]  ne_count;

  logic        c2_in_ready, c2_out_valid, c2_out_illegal;
  logic [2:0]  c2_out_type;
  logic [4:0]  c2_out_rd, c2_out_rs1, c2_out_rs2;
  logic [2:0]  c2_out_funct3;
  logic [6:0]  c2_out_funct7;
  logic [31:0] c2_out_imm;
  logic [1:0]  c2_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .ENABLE_EXT(1'b1), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .out_type(out_type),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct3(out_funct3),
    .out_funct7(out_funct7), .out_imm(out_imm), .out_illegal(out_illegal),
    .illegal_count(illegal_count)
  );

  decode_stage #(.XLEN(32), .ENABLE_EXT(1'b0), .CNT_W(8)) dut_ne (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(ne_in_ready), .out_valid(ne_out_valid), .out_ready(out_ready), .out_type(ne_out_type),
    .out_rd(ne_out_rd), .out_rs1(ne_out_rs1), .out_rs2(ne_out_rs2), .out_funct3(ne_out_funct3),
    .out_funct7(ne_out_funct7), .out_imm(ne_out_imm), .out_illegal(ne_out_illegal),
    .illegal_count(ne_count)
  );

  decode_stage #(.XLEN(32), .ENABLE_EXT(1'b1), .CNT_W(2)) dut_c2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(c2_in_ready), .out_valid(c2_out_valid), .out_ready(out_ready), .out_type(c2_out_type),
    .out_rd(c2_out_rd), .out_rs1(c2_out_rs1), .out_rs2(c2_out_rs2), .out_funct3(c2_out_funct3),
    .out_funct7(c2_out_funct7), .out_imm(c2_out_imm), .out_illegal(c2_out_illegal),
    .illegal_count(c2_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_valid",   64'(out_valid),     64'd0);
    check("rst_ready",   64'(in_ready),      64'd1);
    check("rst_count",   64'(illegal_count), 64'd0);
    check("rst_type",    64'(out_type),      64'd7);
    check("rst_rd",      64'(out_rd),        64'd0);
    check("rst_imm",     64'(out_imm),       64'd0);
    check("rst_illegal", 64'(out_illegal),   64'd1);

    // add x3,x1,x2 then addi x1,x0,-1 and lui x5,0x12345 back to back
    in_valid = 1'b1; in_instr = 32'h002081B3;
    tick();
    check("add_valid", 64'(out_valid),   64'd1);
    check("add_type",  64'(out_type),    64'd0);
    check("add_rd",    64'(out_rd),      64'd3);
    check("add_rs1",   64'(out_rs1),     64'd1);
    check("add_rs2",   64'(out_rs2),     64'd2);
    check("add_imm",   64'(out_imm),     64'd0);
    check("add_ill",   64'(out_illegal), 64'd0);
    in_instr = 32'hFFF00093;
    tick();
    check("addi_type", 64'(out_type), 64'd1);
    check("addi_rd",   64'(out_rd),   64'd1);
    check("addi_imm",  64'(out_imm),  64'hFFFFFFFF);
    in_instr = 32'h123452B7;
    tick();
    check("lui_type", 64'(out_type), 64'd2);
    check("lui_rd",   64'(out_rd),   64'd5);
    check("lui_imm",  64'(out_imm),  64'h12345000);
    in_valid = 1'b0;
    tick();
    check("idle_valid", 64'(out_valid), 64'd0);

    // beq x0,x0,-4: branch on the extended decoder, illegal without extensions
    do_reset();
    in_valid = 1'b1; in_instr = 32'hFE000EE3;
    tick();
    in_valid = 1'b0;
    check("beq_type",    64'(out_type),       64'd4);
    check("beq_imm",     64'(out_imm),        64'hFFFFFFFC);
    check("beq_ill",     64'(out_illegal),    64'd0);
    check("beq_count",   64'(illegal_count),  64'd0);
    check("ne_beq_type", 64'(ne_out_type),    64'd7);
    check("ne_beq_ill",  64'(ne_out_illegal), 64'd1);
    check("ne_beq_cnt",  64'(ne_count),       64'd1);
    check("ne_beq_imm",  64'(ne_out_imm),     64'd0);

    // sw x2,8(x1); jal x1,16; lw x5,-4(x2)
    in_valid = 1'b1; in_instr = 32'h0020A423;
    tick();
    check("sw_type", 64'(out_type), 64'd3);
    check("sw_imm",  64'(out_imm),  64'd8);
    in_instr = 32'h010000EF;
    tick();
    check("jal_type", 64'(out_type), 64'd5);
    check("jal_imm",  64'(out_imm),  64'd16);
    check("jal_rd",   64'(out_rd),   64'd1);
    in_instr = 32'hFFC12283;
    tick();
    in_valid = 1'b0;
    check("lw_type",   64'(out_type),   64'd6);
    check("lw_imm",    64'(out_imm),    64'hFFFFFFFC);
    check("lw_rs1",    64'(out_rs1),    64'd2);
    check("lw_funct3", 64'(out_funct3), 64'd2);
    check("lw_rd",     64'(out_rd),     64'd5);
    check("ne_lw_cnt", 64'(ne_count),   64'd4);

    // Backpressure: four adds with distinct rd, consumer stalled for three cycles
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h002081B3;
    tick();
    check("bp1_valid", 64'(out_valid), 64'd1);
    check("bp1_ready", 64'(in_ready),  64'd1);
    check("bp1_rd",    64'(out_rd),    64'd3);
    in_instr = 32'h00208233;
    tick();
    check("bp2_ready", 64'(in_ready), 64'd0);
    check("bp2_rd",    64'(out_rd),   64'd3);
    in_instr = 32'h002082B3;
    tick();
    check("bp3_ready", 64'(in_ready), 64'd0);
    check("bp3_rd",    64'(out_rd),   64'd3);
    out_ready = 1'b1;
    tick();
    check("bp4_rd",    64'(out_rd),   64'd4);
    check("bp4_ready", 64'(in_ready), 64'd1);
    tick();
    check("bp5_rd", 64'(out_rd), 64'd5);
    in_instr = 32'h00208333;
    tick();
    check("bp6_rd", 64'(out_rd), 64'd6);
    in_valid = 1'b0;
    tick();
    check("bp_drained", 64'(out_valid), 64'd0);

    // Saturation: five all-zero words into the 2-bit counter
    do_reset();
    in_valid = 1'b1; in_instr = 32'h00000000;
    tick();
    check("sat1_c2", 64'(c2_count), 64'd1);
    tick();
    tick();
    check("sat3_c2", 64'(c2_count), 64'd3);
    tick();
    tick();
    check("sat5_c2",   64'(c2_count),      64'd3);
    check("sat5_main", 64'(illegal_count), 64'd5);
    check("sat5_ill",  64'(out_illegal),   64'd1);
    in_valid = 1'b0;
    tick();
    check("sat_hold", 64'(c2_count), 64'd3);

    // Flush with both entries full, then flush of an accepted illegal word, then reset
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00000000;
    tick();
    in_instr = 32'h002081B3;
    tick();
    check("fl_full",  64'(in_ready),      64'd0);
    check("fl_cnt0",  64'(illegal_count), 64'd1);
    flush = 1'b1; in_instr = 32'h00000000;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_valid", 64'(out_valid),     64'd0);
    check("fl_ready", 64'(in_ready),      64'd1);
    check("fl_cnt1",  64'(illegal_count), 64'd1);
    flush = 1'b1; in_valid = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl2_valid", 64'(out_valid),     64'd0);
    check("fl2_cnt",   64'(illegal_count), 64'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("fl_rst_cnt", 64'(illegal_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
